brch_resolve_recovery: RTL and testbench

Branch resolution and misprediction recovery unit for the 5-stage MIPS core. It consumes the IF-stage taken/not-taken prediction from the correlational predictor and the ID-stage actual outcome. It detects mispredictions and drives a one-cycle IF flush plus a PC redirect. It also keeps saturating resolve and mispredict counters for performance monitoring.

---
 rtl/brch_resolve_recovery.sv | 175 +++++++++++++++++
 tb/tb_brch_resolve_recovery.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/brch_resolve_recovery.sv
// -----------------------------------------------------------------------------
// brch_resolve_recovery
//
// Branch resolution and misprediction recovery for the 5-stage MIPS core.
// The IF-stage prediction for a branch is remembered in a pending record
// while the branch moves into ID. When the branch resolves in ID, its actual
// outcome is compared with that record. On a misprediction the unit spends
// exactly one RECOVER cycle. In that cycle it squashes IF/ID and redirects
// the PC to the corrected fetch address. Saturating counters track resolved
// and mispredicted branches for performance monitoring.
//
// Ports
//   clk                    in   1   core clock
//   rst_n                  in   1   synchronous active-low reset
//   brch_instr_detectd_IF  in   1   branch instruction currently in IF
//   predict_br_taken       in   1   predictor output for the IF branch
//   pc_plus4_IF            in  32   fall-through PC of the IF instruction
//   brch_instr_detectd_ID  in   1   branch instruction currently in ID
//   brch_hazard_stall      in   1   IF/ID frozen this cycle
//   actual_brch_result     in   1   resolved outcome of the ID branch (1 = taken)
//   brch_target_ID         in  32   computed taken target of the ID branch
//   mispredict             out  1   registered pulse, recovery in progress
//   flush_IF               out  1   squash the IF/ID pipeline register
//   redirect_valid         out  1   PC must load redirect_pc this cycle
//   redirect_pc            out 32   corrected fetch PC (holds between redirects)
//   br_resolved_cnt        out 16   resolved branches, saturating
//   br_mispred_cnt         out 16   mispredicted branches, saturating
// -----------------------------------------------------------------------------
module brch_resolve_recovery (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        brch_instr_detectd_IF,
    input  logic        predict_br_taken,
    input  logic [31:0] pc_plus4_IF,
    input  logic        brch_instr_detectd_ID,
    input  logic        brch_hazard_stall,
    input  logic        actual_brch_result,
    input  logic [31:0] brch_target_ID,
    output logic        mispredict,
    output logic        flush_IF,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_resolved_cnt,
    output logic [15:0] br_mispred_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state_q, state_d;

    logic        pend_vld_q, pend_vld_d;
    logic        pend_pred_q, pend_pred_d;
    logic [31:0] pend_pc4_q, pend_pc4_d;

    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] resolved_cnt_q, resolved_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    logic        resolve;
    logic        eff_pred;
    logic        miss;

    // Resolution and miss detection.
    // An ID branch with no pending record (for example the first branch after
    // reset) is treated as having been predicted not-taken.
    always_comb begin
        resolve  = 1'b0;
        eff_pred = 1'b0;
        miss     = 1'b0;

        // The ID instruction seen during RECOVER is wrong-path, so it is
        // never resolved.
        resolve  = (state_q == ST_IDLE) && brch_instr_detectd_ID && !brch_hazard_stall;
        eff_pred = pend_vld_q && pend_pred_q;
        miss     = resolve && (actual_brch_result != eff_pred);
    end

    // Next-state logic. RECOVER always lasts exactly one cycle.
    // A stall does not lengthen it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending record. It follows the IF branch into ID.
    // A stall freezes IF/ID, so the record is held and used in the first
    // unstalled cycle. In RECOVER the IF instruction is wrong-path, so the
    // record is dropped whether or not the pipe is stalled.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_pred_d = pend_pred_q;
        pend_pc4_d  = pend_pc4_q;

        if (state_q == ST_RECOVER) begin
            pend_vld_d = 1'b0;
        end else if (!brch_hazard_stall) begin
            pend_vld_d  = brch_instr_detectd_IF;
            pend_pred_d = predict_br_taken;
            pend_pc4_d  = pc_plus4_IF;
        end
    end

    // Redirect target. It is captured on a miss and holds otherwise.
    // A branch that was wrongly predicted not-taken goes to its target.
    // A branch that was wrongly predicted taken falls through to pc+4.
    always_comb begin
        redirect_pc_d = redirect_pc_q;
        if (miss) begin
            redirect_pc_d = actual_brch_result ? brch_target_ID : pend_pc4_q;
        end
    end

    // Saturating performance counters.
    always_comb begin
        resolved_cnt_d = resolved_cnt_q;
        mispred_cnt_d  = mispred_cnt_q;

        if (resolve && (resolved_cnt_q != CNT_MAX)) begin
            resolved_cnt_d = resolved_cnt_q + 16'd1;
        end
        if (miss && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    // State registers.
    // A reset taken during RECOVER returns straight to IDLE, so no flush
    // pulse is produced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pend_vld_q     <= 1'b0;
            pend_pred_q    <= 1'b0;
            pend_pc4_q     <= 32'd0;
            redirect_pc_q  <= 32'd0;
            resolved_cnt_q <= 16'd0;
            mispred_cnt_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            pend_vld_q     <= pend_vld_d;
            pend_pred_q    <= pend_pred_d;
            pend_pc4_q     <= pend_pc4_d;
            redirect_pc_q  <= redirect_pc_d;
            resolved_cnt_q <= resolved_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
        end
    end

    // All recovery outputs come straight from the state register, so they
    // are glitch-free and high for exactly the RECOVER cycle.
    assign mispredict      = (state_q == ST_RECOVER);
    assign flush_IF        = (state_q == ST_RECOVER);
    assign redirect_valid  = (state_q == ST_RECOVER);
    assign redirect_pc     = redirect_pc_q;
    assign br_resolved_cnt = resolved_cnt_q;
    assign br_mispred_cnt  = mispred_cnt_q;

endmodule

// File: tb/tb_brch_resolve_recovery.sv
// -----------------------------------------------------------------------------
// tb_brch_resolve_recovery
//
// Directed bench for brch_resolve_recovery.
// The stimulus pushes each expected redirect target into exp_q.
// A negedge monitor pops and compares whenever redirect_valid is high.
// Flush pulse width, counters and masking are checked inline.
// -----------------------------------------------------------------------------
module tb_brch_resolve_recovery;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        brch_instr_detectd_IF;
    logic        predict_br_taken;
    logic [31:0] pc_plus4_IF;
    logic        brch_instr_detectd_ID;
    logic        brch_hazard_stall;
    logic        actual_brch_result;
    logic [31:0] brch_target_ID;
    logic        mispredict;
    logic        flush_IF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] br_resolved_cnt;
    logic [15:0] br_mispred_cnt;

    always #5 clk = ~clk;

    brch_resolve_recovery dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .brch_instr_detectd_IF (brch_instr_detectd_IF),
        .predict_br_taken      (predict_br_taken),
        .pc_plus4_IF           (pc_plus4_IF),
        .brch_instr_detectd_ID (brch_instr_detectd_ID),
        .brch_hazard_stall     (brch_hazard_stall),
        .actual_brch_result    (actual_brch_result),
        .brch_target_ID        (brch_target_ID),
        .mispredict            (mispredict),
        .flush_IF              (flush_IF),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .br_resolved_cnt       (br_resolved_cnt),
        .br_mispred_cnt        (br_mispred_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (redirect_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_redirect: got redirect to 0x%0h, expected none", redirect_pc);
            end else begin
                check("redirect_pc", redirect_pc, exp_q.pop_front());
                check("mispredict_with_redirect", {31'd0, mispredict}, 32'd1);
                check("flush_with_redirect", {31'd0, flush_IF}, 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic vld, input logic pred, input logic [31:0] pc4);
        brch_instr_detectd_IF = vld;
        predict_br_taken      = pred;
        pc_plus4_IF           = pc4;
    endtask

    task automatic drive_id(input logic vld, input logic act, input logic [31:0] tgt);
        brch_instr_detectd_ID = vld;
        actual_brch_result    = act;
        brch_target_ID        = tgt;
    endtask

    task automatic drive_rand();
        brch_instr_detectd_IF = 1'($urandom_range(0, 1));
        predict_br_taken      = 1'($urandom_range(0, 1));
        pc_plus4_IF           = $urandom;
        brch_instr_detectd_ID = 1'($urandom_range(0, 1));
        brch_hazard_stall     = 1'($urandom_range(0, 1));
        actual_brch_result    = 1'($urandom_range(0, 1));
        brch_target_ID        = $urandom;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_flush_IF"}, {31'd0, flush_IF}, 32'd0);
        check({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
    endtask

    task automatic check_cnts(input string tag, input logic [15:0] res, input logic [15:0] mis);
        check({tag, "_resolved_cnt"}, {16'd0, br_resolved_cnt}, {16'd0, res});
        check({tag, "_mispred_cnt"}, {16'd0, br_mispred_cnt}, {16'd0, mis});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        drive_rand();
        tick();
        drive_rand();
        tick();

        // Release reset with quiet inputs; everything must be zero.
        rst_n = 1'b1;
        drive_if(1'b0, 1'b0, 32'd0);
        drive_id(1'b0, 1'b0, 32'd0);
        brch_hazard_stall = 1'b0;
        check_idle_outputs("reset");
        check("reset_redirect_pc", redirect_pc, 32'd0);
        check_cnts("reset", 16'd0, 16'd0);

        // The first ID branch after reset has no record, so it counts as
        // predicted not-taken. Taken means a miss and a redirect to the target.
        drive_id(1'b1, 1'b1, 32'h200);
        exp_q.push_back(32'h200);
        tick();
        check("norec_flush_n1", {31'd0, flush_IF}, 32'd1);
        check_cnts("norec_n1", 16'd1, 16'd1);
        drive_id(1'b0, 1'b0, 32'd0);
        tick();
        check_idle_outputs("norec_n2");
        check("norec_pc_hold", redirect_pc, 32'h200);

        // Correct taken prediction: no flush is expected.
        drive_if(1'b1, 1'b1, 32'h104);
        tick();
        drive_if(1'b0, 1'b0, 32'd0);
        drive_id(1'b1, 1'b1, 32'h40);
        tick();
        check_idle_outputs("corr_taken");
        check_cnts("corr_taken", 16'd2, 16'd1);
        drive_id(1'b0, 1'b0, 32'd0);

        // Predicted taken, actually not taken: redirect to pc+4 = 0x104.
        // A branch in ID during the RECOVER cycle must be ignored.
        drive_if(1'b1, 1'b1, 32'h104);
        tick();
        drive_if(1'b0, 1'b0, 32'd0);
        drive_id(1'b1, 1'b0, 32'h40);
        exp_q.push_back(32'h104);
        tick();
        check("tmiss_flush_n1", {31'd0, flush_IF}, 32'd1);
        check_cnts("tmiss_n1", 16'd3, 16'd2);
        drive_id(1'b1, 1'b1, 32'h999);   // wrong-path branch, must be masked
        tick();
        drive_id(1'b0, 1'b0, 32'd0);
        check_idle_outputs("mask_n2");
        check_cnts("mask_n2", 16'd3, 16'd2);
        check("mask_pc_hold", redirect_pc, 32'h104);

        // Stall: the record (pred=1, pc4=0x80) is held for 3 stalled cycles.
        // The IF inputs change meanwhile, which must not disturb the record.
        drive_if(1'b1, 1'b1, 32'h80);
        tick();
        brch_hazard_stall = 1'b1;
        drive_if(1'b1, 1'b0, 32'hDEAD);
        drive_id(1'b1, 1'b0, 32'h300);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_flush", {31'd0, flush_IF}, 32'd0);
            check_cnts("stall", 16'd3, 16'd2);
        end
        brch_hazard_stall = 1'b0;
        drive_if(1'b0, 1'b0, 32'd0);
        exp_q.push_back(32'h80);
        tick();
        check("stall_flush_after", {31'd0, flush_IF}, 32'd1);
        check_cnts("stall_after", 16'd4, 16'd3);
        drive_id(1'b0, 1'b0, 32'd0);
        tick();
        check_idle_outputs("stall_n2");

        // Saturation: 65540 correctly predicted not-taken resolves.
        // No record exists, so the effective prediction is not-taken.
        drive_id(1'b1, 1'b0, 32'h500);
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        drive_id(1'b0, 1'b0, 32'd0);
        check_idle_outputs("sat");
        check_cnts("sat", 16'hFFFF, 16'd3);
        tick();
        check_cnts("sat_hold", 16'hFFFF, 16'd3);

        // Reset asserted during RECOVER: back to IDLE with no further pulse.
        drive_id(1'b1, 1'b1, 32'h7000);
        exp_q.push_back(32'h7000);
        tick();
        drive_id(1'b0, 1'b0, 32'd0);
        check("rstrec_flush_n1", {31'd0, flush_IF}, 32'd1);
        check_cnts("rstrec_n1", 16'hFFFF, 16'd4);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("rstrec");
        check("rstrec_redirect_pc", redirect_pc, 32'd0);
        check_cnts("rstrec", 16'd0, 16'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_idle_outputs("final");
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
